// File: rtl/bin_frame_scheduler.sv
// Ping-pong bank controller between the 4x4 binning stage and the frame consumers.
// Packs the binned 1-bit pixel stream into WORD_W-bit words, writes one bank while
// the consumer owns the other, swaps at frame end and grants completed frames over
// a req/grant/done handshake. Frames are dropped (and counted) when the consumer
// still holds the only free bank.
module bin_frame_scheduler #(
  parameter int H_BINS = 320,
  parameter int V_BINS = 180,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              bin_valid_in,
  input  logic [8:0]        bin_h_in,
  input  logic [7:0]        bin_v_in,
  input  logic              bin_px_in,
  output logic              wr_en_out,
  output logic              wr_bank_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [WORD_W-1:0] wr_data_out,
  input  logic              rd_req_in,
  output logic              rd_grant_out,
  output logic              rd_bank_out,
  input  logic              rd_done_in,
  output logic              frame_avail_out,
  output logic [7:0]        frame_id_out,
  output logic [7:0]        drop_cnt_out,
  output logic              sync_err_out
);

  localparam int                WPR       = H_BINS / WORD_W;
  localparam int                BIDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [8:0]        H_LIM     = 9'(H_BINS);
  localparam logic [8:0]        H_LAST    = 9'(H_BINS - 1);
  localparam logic [8:0]        WORD_H    = 9'(WORD_W);
  localparam logic [7:0]        V_LIM     = 8'(V_BINS);
  localparam logic [7:0]        V_LAST    = 8'(V_BINS - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] WPR_A     = ADDR_W'(WPR);

  typedef enum logic {W_WAIT_SOF, W_WRITING} w_state_t;
  typedef enum logic {R_IDLE, R_GRANTED} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic              wb;
  logic              wr_last;
  logic [WORD_W-1:0] pack, pack_nx;
  logic [BIDX_W-1:0] bidx;
  logic [ADDR_W-1:0] word_addr;
  logic              px_ok, sof, word_end, last_px, accept;
  logic              frame_done, hold, swap, drop, grant_now;

  assign wr_bank_out  = wb;
  assign rd_grant_out = (r_state == R_GRANTED);

  // Pixel decode: range filter, start-of-frame, word boundary and the merged word.
  always_comb begin
    px_ok     = bin_valid_in && (bin_h_in < H_LIM) && (bin_v_in < V_LIM);
    sof       = px_ok && (bin_h_in == '0) && (bin_v_in == '0);
    bidx      = BIDX_W'(bin_h_in % WORD_H);
    word_end  = (bidx == BIDX_LAST);
    last_px   = px_ok && (bin_h_in == H_LAST) && (bin_v_in == V_LAST);
    accept    = (w_state == W_WRITING) ? px_ok : sof;
    // A start-of-frame always begins a fresh word, dropping any partial one.
    pack_nx   = sof ? '0 : pack;
    pack_nx[bidx] = bin_px_in;
    word_addr = ADDR_W'(bin_v_in) * WPR_A + ADDR_W'(bin_h_in / WORD_H);
  end

  // Writer next state: any accepted pixel keeps writing unless it closes the frame.
  always_comb begin
    w_next = w_state;
    if (accept) begin
      w_next = (last_px && word_end) ? W_WAIT_SOF : W_WRITING;
    end
  end

  // Writer state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) w_state <= W_WAIT_SOF;
    else           w_state <= w_next;
  end

  // Pack register and one-cycle-latency write port; flag a restart mid-frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pack         <= '0;
      wr_en_out    <= 1'b0;
      wr_addr_out  <= '0;
      wr_data_out  <= '0;
      wr_last      <= 1'b0;
      sync_err_out <= 1'b0;
    end else begin
      wr_en_out <= 1'b0;
      wr_last   <= 1'b0;
      if (accept) begin
        if ((w_state == W_WRITING) && sof) sync_err_out <= 1'b1;
        if (word_end) begin
          wr_en_out   <= 1'b1;
          wr_addr_out <= word_addr;
          wr_data_out <= pack_nx;
          wr_last     <= last_px;
          pack        <= '0;
        end else begin
          pack <= pack_nx;
        end
      end
    end
  end

  // Frame completion is resolved in the cycle the last word is written. A done
  // pulse in that cycle releases the bank first, so the swap still goes ahead.
  always_comb begin
    frame_done = wr_en_out && wr_last;
    hold       = (r_state == R_GRANTED) && !rd_done_in;
    swap       = frame_done && !hold;
    drop       = frame_done && hold;
    grant_now  = (r_state == R_IDLE) && rd_req_in && (swap || frame_avail_out);
    r_next     = r_state;
    case (r_state)
      R_IDLE:    if (grant_now)  r_next = R_GRANTED;
      R_GRANTED: if (rd_done_in) r_next = R_IDLE;
      default:   r_next = R_IDLE;
    endcase
  end

  // Reader state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= R_IDLE;
    else           r_state <= r_next;
  end

  // Bank ownership, availability and frame/drop counters.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wb              <= 1'b0;
      frame_avail_out <= 1'b0;
      frame_id_out    <= '0;
      drop_cnt_out    <= '0;
      rd_bank_out     <= 1'b0;
    end else begin
      if (swap) begin
        wb           <= ~wb;
        frame_id_out <= frame_id_out + 8'd1;
      end
      if (drop && (drop_cnt_out != '1)) drop_cnt_out <= drop_cnt_out + 8'd1;
      // A request landing on the completion cycle is granted the freshly
      // finished frame, which sits in the bank being written right now.
      if (grant_now) begin
        frame_avail_out <= 1'b0;
        rd_bank_out     <= swap ? wb : ~wb;
      end else if (swap) begin
        frame_avail_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_frame_scheduler.sv
// Directed bench for bin_frame_scheduler using a reduced frame height
// (320 x 4 bins, 80 words per frame).
module tb_bin_frame_scheduler;

  localparam int TB_H = 320;
  localparam int TB_V = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        bin_valid_in, bin_px_in;
  logic [8:0]  bin_h_in;
  logic [7:0]  bin_v_in;
  logic        wr_en_out, wr_bank_out;
  logic [11:0] wr_addr_out;
  logic [15:0] wr_data_out;
  logic        rd_req_in, rd_grant_out, rd_bank_out, rd_done_in;
  logic        frame_avail_out, sync_err_out;
  logic [7:0]  frame_id_out, drop_cnt_out;

  int n_cmp = 0;
  int n_bad = 0;

  bin_frame_scheduler #(.H_BINS(TB_H), .V_BINS(TB_V), .WORD_W(16), .ADDR_W(12)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .bin_valid_in(bin_valid_in), .bin_h_in(bin_h_in), .bin_v_in(bin_v_in), .bin_px_in(bin_px_in),
    .wr_en_out(wr_en_out), .wr_bank_out(wr_bank_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .rd_req_in(rd_req_in), .rd_grant_out(rd_grant_out), .rd_bank_out(rd_bank_out), .rd_done_in(rd_done_in),
    .frame_avail_out(frame_avail_out), .frame_id_out(frame_id_out),
    .drop_cnt_out(drop_cnt_out), .sync_err_out(sync_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel pattern: row 0 of seed 0 is 1 on even columns; other rows vary per word.
  function automatic bit pat(input int h, input int v, input int seed);
    int t;
    t = h + 3 * v + seed + (h / 16) * v;
    return (t % 2) == 0;
  endfunction

  function automatic logic [15:0] exp_word(input int v, input int k, input int seed);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[i] = pat(16 * k + i, v, seed);
    return w;
  endfunction

  // Present one pixel; returns 1 ns after the edge that captured it.
  task automatic send(input int h, input int v, input bit p);
    bin_valid_in = 1'b1;
    bin_h_in     = 9'(h);
    bin_v_in     = 8'(v);
    bin_px_in    = p;
    @(posedge clk_in); #1;
  endtask

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  // Stream n_rows rows of a frame, checking every write one cycle after its
  // last column. Returns inside the cycle that carries the final write.
  task automatic send_frame(input int seed, input bit bank, input int n_rows);
    for (int v = 0; v < n_rows; v++) begin
      for (int h = 0; h < TB_H; h++) begin
        send(h, v, pat(h, v, seed));
        if (h % 16 == 15) begin
          chk("wr_en", wr_en_out, 1);
          chk("wr_addr", wr_addr_out, 32'(v * 20 + h / 16));
          chk("wr_data", wr_data_out, exp_word(v, h / 16, seed));
          chk("wr_bank", wr_bank_out, bank);
          if (seed == 0 && v == 0) chk("row0_5555", wr_data_out, 16'h5555);
        end else begin
          chk("wr_en_idle", wr_en_out, 0);
        end
      end
    end
    bin_valid_in = 1'b0;
  endtask

  task automatic chk_state(input string tag, input bit wb, input bit avail, input int id,
                           input int drops, input bit grant);
    chk({tag, "_wb"}, wr_bank_out, wb);
    chk({tag, "_avail"}, frame_avail_out, avail);
    chk({tag, "_id"}, frame_id_out, id);
    chk({tag, "_drop"}, drop_cnt_out, drops);
    chk({tag, "_grant"}, rd_grant_out, grant);
  endtask

  initial begin
    rst_n_in = 1'b1; bin_valid_in = 1'b0; bin_h_in = '0; bin_v_in = '0; bin_px_in = 1'b0;
    rd_req_in = 1'b0; rd_done_in = 1'b0;
    #1 rst_n_in = 1'b0;
    #1;
    chk("rst0_wr_en", wr_en_out, 0);
    chk("rst0_grant", rd_grant_out, 0);
    chk_state("rst0", 0, 0, 0, 0, 0);
    step();
    rst_n_in = 1'b1;
    step();

    // Frame 1: first row checked against the 5555 pattern, whole frame into bank 0.
    send_frame(0, 0, TB_V);
    step();
    chk_state("f1", 1, 1, 1, 0, 0);

    // Handshake: grant the finished frame from bank 0.
    rd_req_in = 1'b1;
    step();
    rd_req_in = 1'b0;
    chk("t3_grant", rd_grant_out, 1);
    chk("t3_rd_bank", rd_bank_out, 0);
    chk("t3_avail", frame_avail_out, 0);

    // Frame 2 completes while bank 0 is still held: dropped.
    send_frame(1, 1, TB_V);
    step();
    chk_state("t4_drop", 1, 0, 1, 1, 1);
    chk("t4_rd_bank", rd_bank_out, 0);

    rd_done_in = 1'b1;
    step();
    rd_done_in = 1'b0;
    chk("t3_release", rd_grant_out, 0);
    // Done while idle and a request with nothing available change nothing.
    rd_done_in = 1'b1;
    step();
    rd_done_in = 1'b0;
    rd_req_in = 1'b1;
    step(); step(); step();
    rd_req_in = 1'b0;
    chk_state("t3_holdoff", 1, 0, 1, 1, 0);

    // Frame 3 swaps normally.
    send_frame(2, 1, TB_V);
    step();
    chk_state("f3", 0, 1, 2, 1, 0);

    // Done in the same cycle as frame 4 completion: release wins, swap proceeds.
    rd_req_in = 1'b1;
    step();
    rd_req_in = 1'b0;
    chk("t5_grant", rd_grant_out, 1);
    chk("t5_rd_bank", rd_bank_out, 1);
    send_frame(3, 0, TB_V);
    rd_done_in = 1'b1;
    step();
    rd_done_in = 1'b0;
    chk_state("t5_done_col", 1, 1, 3, 1, 0);

    // Request in the same cycle as frame 5 completion: grant the new frame.
    send_frame(4, 1, TB_V);
    rd_req_in = 1'b1;
    step();
    rd_req_in = 1'b0;
    chk_state("t5_req_col", 0, 0, 4, 1, 1);
    chk("t5_req_rd_bank", rd_bank_out, 1);

    // Desync: a new start-of-frame in the middle of frame 6.
    rd_done_in = 1'b1;
    step();
    rd_done_in = 1'b0;
    send_frame(5, 0, TB_V / 2);
    chk("t6_no_err_yet", sync_err_out, 0);
    send(0, 0, pat(0, 0, 6));
    chk("t6_sync_err", sync_err_out, 1);
    chk_state("t6_no_swap", 0, 0, 4, 1, 0);
    send_frame(6, 0, TB_V);
    step();
    chk_state("t6_f7", 1, 1, 5, 1, 0);
    chk("t6_sticky", sync_err_out, 1);

    // Async reset in the middle of a grant and a frame.
    rd_req_in = 1'b1;
    step();
    rd_req_in = 1'b0;
    chk("t1_pre_grant", rd_grant_out, 1);
    for (int h = 0; h < 16; h++) send(h, 0, 1'b1);
    bin_valid_in = 1'b0;
    chk("t1_pre_wr_en", wr_en_out, 1);
    chk("t1_pre_data", wr_data_out, 16'hFFFF);
    #2 rst_n_in = 1'b0;
    #1;
    chk("t1_wr_en", wr_en_out, 0);
    chk("t1_wr_data", wr_data_out, 0);
    chk("t1_wr_addr", wr_addr_out, 0);
    chk("t1_rd_bank", rd_bank_out, 0);
    chk("t1_sync_err", sync_err_out, 0);
    chk_state("t1_rst", 0, 0, 0, 0, 0);
    step();
    rst_n_in = 1'b1;

    // No writes until a valid start-of-frame; out-of-range pixels are ignored.
    send(0, TB_V, 1'b1);
    chk("t1_oor_v", wr_en_out, 0);
    for (int h = 1; h < 32; h++) begin
      send(h, 0, 1'b1);
      chk("t1_no_sof", wr_en_out, 0);
    end
    for (int h = 0; h < 15; h++) send(h, 0, 1'b1);
    send(335, 0, 1'b1);
    chk("t1_oor_h", wr_en_out, 0);
    send(15, 0, 1'b1);
    bin_valid_in = 1'b0;
    chk("t1_sof_wr_en", wr_en_out, 1);
    chk("t1_sof_bank", wr_bank_out, 0);
    chk("t1_sof_addr", wr_addr_out, 0);
    chk("t1_sof_data", wr_data_out, 16'hFFFF);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
